// File: rtl/rsa_modexp_box.sv
// rsa_modexp_box: Avalon-MM register box holding base, exponent and modulus
// operand banks, plus a bit-serial engine computing base^exp mod n.
// The modular multiply is interleaved shift-add, one multiplier bit per cycle,
// so every multiply costs exactly KEY_W cycles and the accumulator stays below n.
module rsa_modexp_box #(
    parameter int KEY_W  = 128,
    parameter int WORD_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              chipselect,
    input  logic              write,
    input  logic [ADDR_W-1:0] address,
    input  logic [WORD_W-1:0] data_in,
    output logic [WORD_W-1:0] data_out,
    output logic              irq
);

    localparam int NWORDS = KEY_W / WORD_W;
    localparam int IDX_W  = $clog2(KEY_W);
    localparam int ACC_W  = KEY_W + 2;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_CHECK = 3'd1;
    localparam logic [2:0] ST_SQR   = 3'd2;
    localparam logic [2:0] ST_MUL   = 3'd3;
    localparam logic [2:0] ST_FIN   = 3'd4;

    logic [KEY_W-1:0]  baseOp_q, baseOp_d;
    logic [KEY_W-1:0]  expOp_q, expOp_d;
    logic [KEY_W-1:0]  modulus_q, modulus_d;
    logic [KEY_W-1:0]  result_q, result_d;
    logic [KEY_W-1:0]  rAcc_q, rAcc_d;
    logic [KEY_W-1:0]  p_q, p_d;
    logic [IDX_W-1:0]  bitIdx_q, bitIdx_d;
    logic [IDX_W-1:0]  cycIdx_q, cycIdx_d;
    logic [2:0]        state_q, state_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              irqEn_q, irqEn_d;
    logic [WORD_W-1:0] readData_q, readData_d;

    logic              busy;
    logic              busWrite;
    logic              ctrlWrite;
    logic              startReq;
    logic              clearReq;
    logic [WORD_W-1:0] readMux;
    logic              mulY;
    logic [ACC_W-1:0]  modExt;
    logic [ACC_W-1:0]  accSum;
    logic [ACC_W-1:0]  accOne;
    logic [ACC_W-1:0]  accTwo;
    logic [1:0]        unusedAccHi;

    assign busy      = (state_q != ST_IDLE);
    assign busWrite  = chipselect & write;
    assign ctrlWrite = busWrite & (address == '0);
    // CLEAR takes priority, so a combined CLEAR+START never launches a run.
    assign startReq  = ctrlWrite & data_in[0] & ~data_in[1];
    assign clearReq  = ctrlWrite & data_in[1];
    assign irq       = done_q & irqEn_q;
    assign data_out  = readData_q;

    // Operand bank writes, locked out while the engine is running.
    always_comb begin
        baseOp_d  = baseOp_q;
        expOp_d   = expOp_q;
        modulus_d = modulus_q;
        if (busWrite && !busy) begin
            for (int k = 0; k < NWORDS; k++) begin
                if (address == ADDR_W'(1 + k))
                    baseOp_d[k*WORD_W +: WORD_W] = data_in;
                if (address == ADDR_W'(1 + NWORDS + k))
                    expOp_d[k*WORD_W +: WORD_W] = data_in;
                if (address == ADDR_W'(1 + 2*NWORDS + k))
                    modulus_d[k*WORD_W +: WORD_W] = data_in;
            end
        end
    end

    // Read multiplexer; unmapped addresses return zero.
    always_comb begin
        readMux = '0;
        if (address == '0)
            readMux[3:0] = {err_q, irqEn_q, done_q, busy};
        for (int k = 0; k < NWORDS; k++) begin
            if (address == ADDR_W'(1 + k))
                readMux = baseOp_q[k*WORD_W +: WORD_W];
            if (address == ADDR_W'(1 + NWORDS + k))
                readMux = expOp_q[k*WORD_W +: WORD_W];
            if (address == ADDR_W'(1 + 2*NWORDS + k))
                readMux = modulus_q[k*WORD_W +: WORD_W];
            if (address == ADDR_W'(1 + 3*NWORDS + k))
                readMux = result_q[k*WORD_W +: WORD_W];
        end
        readData_d = (chipselect && !write) ? readMux : readData_q;
    end

    // One shift-add step of R*Y mod n; two subtractions suffice since 2P+X < 3n.
    always_comb begin
        mulY        = (state_q == ST_MUL) ? baseOp_q[cycIdx_q] : rAcc_q[cycIdx_q];
        modExt      = {2'b00, modulus_q};
        accSum      = {1'b0, p_q, 1'b0} + (mulY ? {2'b00, rAcc_q} : '0);
        accOne      = (accSum >= modExt) ? (accSum - modExt) : accSum;
        accTwo      = (accOne >= modExt) ? (accOne - modExt) : accOne;
        unusedAccHi = accTwo[ACC_W-1:KEY_W];
    end

    // Control FSM: left-to-right square-and-multiply over every exponent bit.
    always_comb begin
        state_d  = state_q;
        rAcc_d   = rAcc_q;
        p_d      = p_q;
        bitIdx_d = bitIdx_q;
        cycIdx_d = cycIdx_q;
        result_d = result_q;
        done_d   = done_q;
        err_d    = err_q;
        irqEn_d  = ctrlWrite ? data_in[2] : irqEn_q;

        case (state_q)
            ST_IDLE: begin
                if (clearReq) begin
                    done_d   = 1'b0;
                    err_d    = 1'b0;
                    result_d = '0;
                end else if (startReq) begin
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if ((modulus_q == '0) || (baseOp_q >= modulus_q)) begin
                    err_d   = 1'b1;
                    state_d = ST_FIN;
                end else begin
                    rAcc_d   = (modulus_q == KEY_W'(1)) ? '0 : KEY_W'(1);
                    p_d      = '0;
                    bitIdx_d = IDX_W'(KEY_W - 1);
                    cycIdx_d = IDX_W'(KEY_W - 1);
                    state_d  = ST_SQR;
                end
            end
            ST_SQR, ST_MUL: begin
                p_d      = accTwo[KEY_W-1:0];
                cycIdx_d = cycIdx_q - 1'b1;
                if (cycIdx_q == '0) begin
                    rAcc_d   = accTwo[KEY_W-1:0];
                    p_d      = '0;
                    cycIdx_d = IDX_W'(KEY_W - 1);
                    if ((state_q == ST_SQR) && expOp_q[bitIdx_q]) begin
                        state_d = ST_MUL;
                    end else if (bitIdx_q == '0) begin
                        state_d = ST_FIN;
                    end else begin
                        bitIdx_d = bitIdx_q - 1'b1;
                        state_d  = ST_SQR;
                    end
                end
            end
            ST_FIN: begin
                result_d = err_q ? '0 : rAcc_q;
                done_d   = 1'b1;
                state_d  = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // An abort keeps the previous result but drops the status flags.
        if (clearReq && busy) begin
            state_d = ST_IDLE;
            done_d  = 1'b0;
            err_d   = 1'b0;
        end
    end

    // State registers; reset clears every bank, flag and the read buffer.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            baseOp_q   <= '0;
            expOp_q    <= '0;
            modulus_q  <= '0;
            result_q   <= '0;
            rAcc_q     <= '0;
            p_q        <= '0;
            bitIdx_q   <= '0;
            cycIdx_q   <= '0;
            state_q    <= ST_IDLE;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            irqEn_q    <= 1'b0;
            readData_q <= '0;
        end else begin
            baseOp_q   <= baseOp_d;
            expOp_q    <= expOp_d;
            modulus_q  <= modulus_d;
            result_q   <= result_d;
            rAcc_q     <= rAcc_d;
            p_q        <= p_d;
            bitIdx_q   <= bitIdx_d;
            cycIdx_q   <= cycIdx_d;
            state_q    <= state_d;
            done_q     <= done_d;
            err_q      <= err_d;
            irqEn_q    <= irqEn_d;
            readData_q <= readData_d;
        end
    end

endmodule

// File: tb/tb_rsa_modexp_box.sv
// tb_rsa_modexp_box: directed bench for rsa_modexp_box. Reads push their
// expected word into a scoreboard; a monitor pops and compares whenever the
// registered read data becomes valid.
module tb_rsa_modexp_box;

    localparam int KEY_W     = 128;
    localparam int WORD_W    = 32;
    localparam int ADDR_W    = 5;
    localparam int NWORDS    = 4;
    localparam int BASE_ADDR = 1;
    localparam int EXP_ADDR  = 5;
    localparam int MOD_ADDR  = 9;
    localparam int RES_ADDR  = 13;

    logic              clk;
    logic              reset;
    logic              chipselect;
    logic              write;
    logic [ADDR_W-1:0] address;
    logic [WORD_W-1:0] data_in;
    logic [WORD_W-1:0] data_out;
    logic              irq;

    int           checks;
    int           errors;
    int           cycleCnt;
    int           lastWriteCycle;
    int           startCyc;
    logic         rdValid;
    logic [31:0]  expQ[$];
    string        tagQ[$];
    logic [127:0] fwBase;
    logic [127:0] fwExp;
    logic [127:0] fwMod;
    logic [127:0] fwRes;

    rsa_modexp_box #(
        .KEY_W (KEY_W),
        .WORD_W(WORD_W),
        .ADDR_W(ADDR_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .chipselect(chipselect),
        .write     (write),
        .address   (address),
        .data_in   (data_in),
        .data_out  (data_out),
        .irq       (irq)
    );

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Cycle counter used to time START-to-done latency.
    initial cycleCnt = 0;
    always @(posedge clk) cycleCnt <= cycleCnt + 1;

    // Read data is valid the cycle after a read access.
    always @(posedge clk or negedge reset) begin
        if (!reset) rdValid <= 1'b0;
        else        rdValid <= chipselect & ~write;
    end

    // Golden model: right-to-left square-and-multiply using wide % arithmetic.
    function automatic logic [127:0] modexpModel(input logic [127:0] b,
                                                 input logic [127:0] e,
                                                 input logic [127:0] n);
        logic [255:0] r;
        logic [255:0] x;
        logic [255:0] nn;
        nn = {128'd0, n};
        r  = 256'd1 % nn;
        x  = {128'd0, b} % nn;
        for (int i = 0; i < 128; i++) begin
            if (e[i]) r = (r * x) % nn;
            x = (x * x) % nn;
        end
        return r[127:0];
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input int addr, input logic [31:0] data);
        @(negedge clk);
        chipselect = 1'b1;
        write      = 1'b1;
        address    = ADDR_W'(addr);
        data_in    = data;
        @(negedge clk);
        chipselect = 1'b0;
        write      = 1'b0;
        lastWriteCycle = cycleCnt;
    endtask

    task automatic readExpect(input int addr, input logic [31:0] expected,
                              input string tag);
        expQ.push_back(expected);
        tagQ.push_back(tag);
        @(negedge clk);
        chipselect = 1'b1;
        write      = 1'b0;
        address    = ADDR_W'(addr);
        @(negedge clk);
        chipselect = 1'b0;
    endtask

    task automatic loadOperand(input int bankAddr, input logic [127:0] value);
        for (int k = 0; k < NWORDS; k++)
            applyStimulus(bankAddr + k, value[k*32 +: 32]);
    endtask

    task automatic expectResult(input logic [127:0] value, input string tag);
        for (int k = 0; k < NWORDS; k++)
            readExpect(RES_ADDR + k, value[k*32 +: 32], $sformatf("%s_result%0d", tag, k));
    endtask

    task automatic waitIrq(input int fromCyc, input int expLat, input string tag);
        while (!irq && ((cycleCnt - fromCyc) < expLat + 50)) @(negedge clk);
        if (!irq) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s: irq never rose, waited %0d cycles, expected %0d",
                     tag, cycleCnt - fromCyc, expLat);
        end else begin
            checkOutput(tag, 32'(cycleCnt - fromCyc), 32'(expLat));
        end
    endtask

    // Scoreboard monitor: compares each valid read against the queued expectation.
    always @(negedge clk) begin
        if (rdValid) begin
            if (expQ.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpectedRead: got 0x%0h, expected no read", data_out);
            end else begin
                checkOutput(tagQ.pop_front(), data_out, expQ.pop_front());
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #1500000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed stimulus sequence.
    initial begin
        checks     = 0;
        errors     = 0;
        chipselect = 1'b0;
        write      = 1'b0;
        address    = '0;
        data_in    = '0;
        reset      = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;

        checkOutput("irqAfterReset", 32'(irq), 32'd0);
        readExpect(0, 32'h0, "statusAfterReset");

        $display("[TB] basic 4^13 mod 497 with busy-time protocol checks");
        loadOperand(BASE_ADDR, 128'd4);
        loadOperand(EXP_ADDR, 128'd13);
        loadOperand(MOD_ADDR, 128'd497);
        applyStimulus(0, 32'h5);
        startCyc = lastWriteCycle;
        readExpect(0, 32'h5, "statusBusy");
        applyStimulus(EXP_ADDR, 32'd99);
        readExpect(EXP_ADDR, 32'd13, "expHeldWhileBusy");
        applyStimulus(0, 32'h5);
        waitIrq(startCyc, 2 + 128*131, "latencyBasic");
        checkOutput("irqBasic", 32'(irq), 32'd1);
        readExpect(0, 32'h6, "statusDoneBasic");
        expectResult(128'd445, "basic");

        $display("[TB] zero exponent");
        loadOperand(BASE_ADDR, 128'd7);
        loadOperand(EXP_ADDR, 128'd0);
        loadOperand(MOD_ADDR, 128'd13);
        applyStimulus(0, 32'h5);
        waitIrq(lastWriteCycle, 2 + 128*128, "latencyZeroExp");
        expectResult(128'd1, "zeroExp");

        $display("[TB] modulus one");
        loadOperand(BASE_ADDR, 128'd0);
        loadOperand(MOD_ADDR, 128'd1);
        applyStimulus(0, 32'h5);
        waitIrq(lastWriteCycle, 2 + 128*128, "latencyModOne");
        readExpect(0, 32'h6, "statusModOne");
        expectResult(128'd0, "modOne");

        $display("[TB] full width operands");
        fwBase = (128'd1 << 127) - 128'd1;
        fwExp  = 128'd65537;
        fwMod  = {128{1'b1}} - 128'd158;
        fwRes  = modexpModel(fwBase, fwExp, fwMod);
        loadOperand(BASE_ADDR, fwBase);
        loadOperand(EXP_ADDR, fwExp);
        loadOperand(MOD_ADDR, fwMod);
        applyStimulus(0, 32'h5);
        waitIrq(lastWriteCycle, 2 + 128*130, "latencyFullWidth");
        expectResult(fwRes, "fullWidth");

        $display("[TB] abort and clear");
        applyStimulus(0, 32'h5);
        repeat (30) @(negedge clk);
        applyStimulus(0, 32'h6);
        checkOutput("irqAfterAbort", 32'(irq), 32'd0);
        readExpect(0, 32'h4, "statusAfterAbort");
        expectResult(fwRes, "abortKeeps");
        applyStimulus(0, 32'h6);
        expectResult(128'd0, "clearIdle");
        readExpect(BASE_ADDR, 32'hFFFF_FFFF, "baseKeptAfterClear");
        applyStimulus(0, 32'h7);
        readExpect(0, 32'h4, "clearBeatsStart");

        $display("[TB] error paths");
        loadOperand(MOD_ADDR, 128'd0);
        applyStimulus(0, 32'h5);
        waitIrq(lastWriteCycle, 2, "latencyErrZeroMod");
        readExpect(0, 32'hE, "statusErrZeroMod");
        expectResult(128'd0, "errZeroMod");
        loadOperand(BASE_ADDR, 128'd13);
        loadOperand(MOD_ADDR, 128'd13);
        applyStimulus(0, 32'h5);
        waitIrq(lastWriteCycle, 2, "latencyErrBaseEqMod");
        readExpect(0, 32'hE, "statusErrBaseEqMod");
        applyStimulus(0, 32'h0);
        checkOutput("irqMasked", 32'(irq), 32'd0);
        readExpect(0, 32'hA, "statusMasked");

        $display("[TB] reset mid-operation");
        loadOperand(BASE_ADDR, 128'd4);
        loadOperand(EXP_ADDR, 128'd13);
        loadOperand(MOD_ADDR, 128'd497);
        applyStimulus(0, 32'h5);
        repeat (40) @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("irqDuringReset", 32'(irq), 32'd0);
        checkOutput("dataOutAfterReset", data_out, 32'd0);
        reset = 1'b1;
        for (int a = 0; a <= 17; a++)
            readExpect(a, 32'h0, $sformatf("addr%0dAfterReset", a));

        repeat (3) @(negedge clk);
        checkOutput("scoreboardDrained", 32'(expQ.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rsa_modexp_box.md
# rsa_modexp_box

Parametrised successor to the RSA register box: an Avalon-MM slave holding base, exponent and modulus operand banks of KEY_W bits. It also contains a bit-serial modular-exponentiation engine that computes result = base^exp mod n in hardware. Software loads the operands word by word, writes START, then polls status (or takes the interrupt) and reads the result bank. It sits on the lightweight HPS-to-FPGA bus in place of the fixed-width box.

## Interface
- KEY_W, 128: operand width in bits; multiple of WORD_W, ≥ 2*WORD_W.
- WORD_W, 32: bus data width.
- NWORDS, KEY_W/WORD_W: derived; words per operand.
- ADDR_W, 5: address width; must satisfy 2^ADDR_W ≥ 4*NWORDS+1.
- clk  in  1  single clock for all logic.
- reset  in  1  asynchronous, active-low (asserted at 0); clears every register.
- chipselect  in  1  bus access qualifier.
- write  in  1  1 = write, 0 = read (when chipselect=1).
- address  in  ADDR_W  word address.
- data_in  in  WORD_W  write data.
- data_out  out  WORD_W  registered read data; reset 0.
- irq  out  1  done & irq_en; reset 0.

## Operation
- Address map (word k of each bank: k=0 is least significant):
  - 0: CTRL/STATUS. Write: bit0 START, bit1 CLEAR, bit2 irq_en (stored). Read: bit0 busy, bit1 done, bit2 irq_en, bit3 err; other bits 0.
  - 1..NWORDS: base. NWORDS+1..2N: exp. 2N+1..3N: modulus n. All are read/write.
  - 3N+1..4N: result, read-only. Higher addresses read 0 and ignore writes.
- Operand writes are ignored while busy=1. START while busy=1 is ignored. CLEAR while busy=1 aborts the operation and returns to IDLE; result is kept and done/err are cleared.
- CLEAR when idle: clears done, err, result; operands are kept.
- START when idle: clears done and err, then enters CHECK.
- FSM states IDLE, CHECK, SQR, MUL, FIN:
  - CHECK (1 cycle): if n==0 or base≥n, go to FIN with err=1 and result=0.
    - Otherwise R←(n==1 ? 0 : 1), bit index i←KEY_W-1, go to SQR.
  - SQR: R←R·R mod n (KEY_W cycles). Then, if exp[i]=1, go to MUL; otherwise go to the next-bit step.
  - MUL: R←R·base mod n (KEY_W cycles), then the next-bit step.
  - Next-bit step: if i==0, go to FIN; otherwise i←i-1 and go to SQR.
  - FIN (1 cycle): result←R (or 0 if err), done←1, busy←0, go to IDLE.
- Modular multiply X·Y mod n is interleaved shift-add, MSB of Y first. One bit per cycle: P←2P + (Y[j]?X:0), then up to two conditional subtractions of n.
  - Accumulator width is KEY_W+2.
  - Invariant: P<n after every cycle.
- Leading zero bits of exp are not skipped. Latency is data-dependent only through popcount(exp).
- busy = state≠IDLE.

## Timing
- Reads: data_out updates on the edge after a chipselect&!write cycle, so read latency is 1. data_out holds its value otherwise.
- START is sampled on the write edge; busy reads 1 from the next cycle.
- Valid operands: done=1 exactly 2 + KEY_W·(KEY_W + popcount(exp)) cycles after the START edge.
- err path: done=1 exactly 2 cycles after the START edge.
- irq asserts the same cycle done rises (if irq_en=1). It stays high until CLEAR, START, or a write of irq_en=0.
- A START and an operand write cannot coincide, because there is a single address per access.
- CLEAR and START set in the same write: CLEAR wins and START is ignored.
- reset asserted mid-operation: immediate return to IDLE. All banks, status, data_out and irq are 0.

## Test plan
- Reset: drive reset=0 mid-SQR with nonzero operands -> all reads return 0, irq=0, busy=0 after release.
- Basic: base=4, exp=13, n=497 -> result word0=445, upper words 0; done after 2+128·131=16770 cycles; irq high with irq_en=1.
- Zero exponent: base=7, exp=0, n=13 -> result=1, latency 2+128·128. Then n=1 -> result=0.
- Full width: base=2^127-1, exp=65537, n=2^128-159 -> result matches the golden model. Verifies word ordering across all 4 words.
- Errors: n=0 -> err=1, done=1 in 2 cycles, result=0. base=13, n=13 -> err=1.
- Protocol: START then write exp while busy -> exp unchanged. Second START ignored. CLEAR mid-run -> busy=0, done=0 next cycle, prior result retained.
